fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 59 +++++
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and FSM state type for the fetch sequencer slice.
package fetch_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_PROG_LEN = 26;
    localparam int DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction word and its PC.
// Captures the in-flight ROM word when decode stalls, so the PC register
// can stop while the word stays presentable.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              rel,
    input  logic              flush,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc
);

    logic              full_d, full_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [ADDR_W-1:0] pc_d,   pc_q;

    // Next-state: flush wins, then load; release just empties the entry.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            data_d = load_data;
            pc_d   = load_pc;
        end else if (rel) begin
            full_d = 1'b0;
        end
    end

    // Buffer registers; asynchronous reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            pc_q   <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign full = full_q;
    assign data = data_q;
    assign pc   = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, issue control and valid/ready output stage in front of
// a registered-read instruction ROM. Handles redirects (squashing the
// in-flight word and any skid content) and halts after the last word.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int PROG_LEN = DEF_PROG_LEN,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_ins,
    output logic [DATA_W-1:0] ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PROG_LIMIT = ADDR_W'(PROG_LEN);
    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0] START_PC   = ADDR_W'(RESET_PC);

    fetch_state_t      state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              inflight_d, inflight_q;
    logic [ADDR_W-1:0] inflight_pc_d, inflight_pc_q;

    logic              issue;
    logic              xfer;
    logic              skid_load, skid_rel, skid_flush;
    logic              skid_full;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .rel       (skid_rel),
        .flush     (skid_flush),
        .load_data (mem_ins),
        .load_pc   (inflight_pc_q),
        .full      (skid_full),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    // Output mux: the skid entry is always older than anything in flight.
    always_comb begin
        ins_valid = skid_full | inflight_q;
        ins_out   = '0;
        ins_pc    = '0;
        if (skid_full) begin
            ins_out = skid_data;
            ins_pc  = skid_pc;
        end else if (inflight_q) begin
            ins_out = mem_ins;
            ins_pc  = inflight_pc_q;
        end
    end

    assign mem_addr = pc_q;
    assign halted   = (state_q == ST_DONE);

    // Issue, skid control, PC update and FSM; redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        skid_load     = 1'b0;
        skid_rel      = 1'b0;
        skid_flush    = 1'b0;
        issue         = (state_q == ST_FETCH) && (ins_ready || !ins_valid);
        xfer          = ins_valid && ins_ready;

        if (redirect) begin
            pc_d       = redirect_pc;
            skid_flush = 1'b1;
            state_d    = (redirect_pc >= PROG_LIMIT) ? ST_DONE : ST_FETCH;
        end else begin
            // A stalled in-flight word is parked in the skid, and since
            // ins_valid is high with ins_ready low, issue is already 0 here.
            skid_load = inflight_q && !skid_full && !ins_ready;
            skid_rel  = skid_full && ins_ready;
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 1'b1;
            end
            unique case (state_q)
                ST_FETCH: if (issue && (pc_q == LAST_PC)) state_d = ST_DRAIN;
                ST_DRAIN: if (xfer) state_d = ST_DONE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    // Sequencer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= START_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural registered ROM standing in for
// instruction_fetch, a stream-level reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_fetch_sequencer;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int PROG_LEN = 26;
    localparam int RESET_PC = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_ins = '0;
    logic [DATA_W-1:0] ins_out;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_valid;
    logic              ins_ready = 1'b1;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halted;

    logic [DATA_W-1:0] rom [32];

    int tests = 0;
    int fails = 0;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .PROG_LEN (PROG_LEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_ins     (mem_ins),
        .ins_out     (ins_out),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++)
            rom[i] = {8'hA5, 8'(i), 8'(~i), 8'(i * 7 + 3)};
    end

    // Registered one-cycle ROM read.
    always @(posedge clk) mem_ins <= rom[mem_addr[4:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: in-order PCs from the current start point, one bubble
    // after reset/redirect, held word while stalled, halt once exhausted.
    int                exp_pc = RESET_PC;
    bit                bubble = 1'b1;
    bit                halted_m = 1'b0;
    bit                prev_hold = 1'b0;
    logic [ADDR_W-1:0] prev_pc = '0;
    logic [DATA_W-1:0] prev_data = '0;
    int                xfer_count = 0;
    int                last_xfer_pc = -1;

    always @(negedge clk) begin
        bit exp_valid;
        bit xfer;
        if (!rst_n) begin
            chk("rst_valid", 32'(ins_valid), 32'd0);
            chk("rst_out", ins_out, 32'd0);
            chk("rst_pc", 32'(ins_pc), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
            chk("rst_addr", 32'(mem_addr), 32'(RESET_PC));
            exp_pc     = RESET_PC;
            bubble     = 1'b1;
            halted_m   = 1'b0;
            prev_hold  = 1'b0;
            xfer_count = 0;
        end else begin
            exp_valid = !bubble && !halted_m;
            chk("valid", 32'(ins_valid), 32'(exp_valid));
            chk("halted", 32'(halted), 32'(halted_m));
            if (exp_valid) begin
                chk("ins_pc", 32'(ins_pc), 32'(exp_pc));
                chk("ins_out", ins_out, rom[exp_pc]);
            end else begin
                chk("idle_out", ins_out, 32'd0);
                chk("idle_pc", 32'(ins_pc), 32'd0);
            end
            if (prev_hold) begin
                chk("hold_pc", 32'(ins_pc), 32'(prev_pc));
                chk("hold_out", ins_out, prev_data);
            end
            xfer = exp_valid && ins_ready;
            if (xfer) begin
                xfer_count++;
                last_xfer_pc = exp_pc;
                exp_pc++;
            end
            if (redirect) begin
                exp_pc    = int'(redirect_pc);
                halted_m  = (exp_pc >= PROG_LEN);
                bubble    = 1'b1;
                prev_hold = 1'b0;
            end else begin
                if (xfer && exp_pc == PROG_LEN) halted_m = 1'b1;
                bubble    = 1'b0;
                prev_hold = exp_valid && !ins_ready;
                prev_pc   = ins_pc;
                prev_data = ins_out;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input int target, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (ins_valid && int'(ins_pc) == target) found = 1'b1;
            else step();
        end
        chk($sformatf("wait_pc_%0d", target), 32'(found), 32'd1);
    endtask

    initial begin
        int n;
        // Reset release and free-running stream to halt.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("first_cycle_valid", 32'(ins_valid), 32'd0);
        chk("first_cycle_addr", 32'(mem_addr), 32'd0);
        step();
        chk("first_valid", 32'(ins_valid), 32'd1);
        chk("first_pc", 32'(ins_pc), 32'd0);
        chk("first_word", ins_out, 32'hA500FF03);
        n = 1;
        while (!halted && n < 60) begin
            step();
            n++;
        end
        chk("halt_latency", 32'(n), 32'd27);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("xfer_total", 32'(xfer_count), 32'd26);
        chk("last_xfer_pc", 32'(last_xfer_pc), 32'd25);

        // Restart from DONE, then a 3-cycle stall on pc 5.
        redirect = 1'b1;
        redirect_pc = 16'd0;
        step();
        redirect = 1'b0;
        chk("restart_halted", 32'(halted), 32'd0);
        chk("restart_bubble", 32'(ins_valid), 32'd0);
        wait_pc(5, 20);
        ins_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc5", 32'(ins_pc), 32'd5);
        end
        ins_ready = 1'b1;
        step();
        chk("after_stall_6", 32'(ins_pc), 32'd6);
        step();
        chk("after_stall_7", 32'(ins_pc), 32'd7);

        // Redirect to 20 while pc 8 is presented and accepted.
        wait_pc(8, 10);
        redirect = 1'b1;
        redirect_pc = 16'd20;
        step();
        redirect = 1'b0;
        chk("redir_bubble", 32'(ins_valid), 32'd0);
        step();
        chk("redir_target", 32'(ins_pc), 32'd20);
        chk("redir_word", ins_out, 32'hA514EB8F);

        // Redirect while the skid holds pc 21 and decode is stalled.
        wait_pc(21, 5);
        ins_ready = 1'b0;
        step();
        step();
        chk("skid_pc21", 32'(ins_pc), 32'd21);
        redirect = 1'b1;
        redirect_pc = 16'd3;
        step();
        redirect = 1'b0;
        chk("flush_bubble", 32'(ins_valid), 32'd0);
        step();
        chk("flush_target", 32'(ins_pc), 32'd3);
        ins_ready = 1'b1;
        step();
        chk("flush_next", 32'(ins_pc), 32'd4);

        // Redirect beyond the program, then restart at 0.
        redirect = 1'b1;
        redirect_pc = 16'd30;
        step();
        redirect = 1'b0;
        chk("oob_halted", 32'(halted), 32'd1);
        chk("oob_valid", 32'(ins_valid), 32'd0);
        step();
        chk("oob_stays", 32'(halted), 32'd1);
        redirect = 1'b1;
        redirect_pc = 16'd0;
        step();
        redirect = 1'b0;
        chk("oob_restart", 32'(halted), 32'd0);
        step();
        chk("oob_restart_pc", 32'(ins_pc), 32'd0);
        chk("oob_restart_v", 32'(ins_valid), 32'd1);

        // Asynchronous reset in the middle of a stall at pc 12.
        wait_pc(12, 20);
        ins_ready = 1'b0;
        step();
        step();
        chk("stall_pc12", 32'(ins_pc), 32'd12);
        #3;
        rst_n = 1'b0;
        #2;
        chk("async_valid", 32'(ins_valid), 32'd0);
        chk("async_pc", 32'(ins_pc), 32'd0);
        chk("async_out", ins_out, 32'd0);
        chk("async_addr", 32'(mem_addr), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        ins_ready = 1'b1;
        step();
        chk("post_rst_pc", 32'(ins_pc), 32'd0);
        chk("post_rst_v", 32'(ins_valid), 32'd1);
        wait_pc(4, 10);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog against a hung scenario.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
